biquad_coeff_sequencer: RTL

Sequences coefficient updates into one `biquad_filter` instance so that a new a1/a2/b0/b1/b2 set is applied atomically, never in the middle of a sample computation. Software writes the staged set into the register bank and pulses a commit. This block waits for a quiet point, swaps the set in, pulses the filter's reinit, and mutes the downstream path for a programmable number of output samples while the filter state settles. It sits between the register bank and the filter's coefficient and reinit inputs.

---
 rtl/pt_feedback_pkg.sv | 23 ++
 rtl/sample_down_counter.sv | 37 +++
 rtl/biquad_coeff_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pt_feedback_pkg.sv
// Shared types for the biquad coefficient sequencer: FSM states and the
// five-coefficient set that is moved as one unit between registers.
package pt_feedback_pkg;

  localparam int DEFAULT_COEFF_WIDTH = 26;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SETTLE  = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [DEFAULT_COEFF_WIDTH-1:0] a1;
    logic [DEFAULT_COEFF_WIDTH-1:0] a2;
    logic [DEFAULT_COEFF_WIDTH-1:0] b0;
    logic [DEFAULT_COEFF_WIDTH-1:0] b1;
    logic [DEFAULT_COEFF_WIDTH-1:0] b2;
  } biquad_coeffs_t;

  localparam biquad_coeffs_t COEFFS_ZERO = '0;

endpackage

// File: rtl/sample_down_counter.sv
// Down-counter loaded with a sample budget and decremented on a strobe;
// flags zero and the strobe that takes it from one to zero.
module sample_down_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign zero_o = (count_q == '0);
  assign done_o = dec_i && !load_i && (count_q == WIDTH'(1));

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// Applies a committed biquad coefficient set atomically at a quiet point,
// pulses the filter reinit and mutes downstream while the filter settles.
//
// state   | meaning
// IDLE    | active set in use, nothing staged for apply
// PENDING | committed set waiting for a cycle with no busy and no input strobe
// SETTLE  | set applied, counting filter output samples before unmuting
//
// COEFF_WIDTH must equal pt_feedback_pkg::DEFAULT_COEFF_WIDTH; the set is
// stored in the package struct.
module biquad_coeff_sequencer
  import pt_feedback_pkg::*;
#(
  parameter int COEFF_WIDTH    = DEFAULT_COEFF_WIDTH,
  parameter int SETTLE_SAMPLES = 16,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [COEFF_WIDTH-1:0] a1_i,
  input  logic [COEFF_WIDTH-1:0] a2_i,
  input  logic [COEFF_WIDTH-1:0] b0_i,
  input  logic [COEFF_WIDTH-1:0] b1_i,
  input  logic [COEFF_WIDTH-1:0] b2_i,
  input  logic                   commit_i,
  input  logic                   data_valid_i,
  input  logic                   busy_i,
  input  logic                   filter_valid_i,
  output logic [COEFF_WIDTH-1:0] a1_o,
  output logic [COEFF_WIDTH-1:0] a2_o,
  output logic [COEFF_WIDTH-1:0] b0_o,
  output logic [COEFF_WIDTH-1:0] b1_o,
  output logic [COEFF_WIDTH-1:0] b2_o,
  output logic                   reinit_o,
  output logic                   mute_o,
  output logic                   pending_o,
  output logic [COUNT_WIDTH-1:0] update_count_o
);

  localparam int CNT_W = (SETTLE_SAMPLES < 2) ? 1 : $clog2(SETTLE_SAMPLES + 1);

  seq_state_e             state_q, state_d;
  biquad_coeffs_t         shadow_q, shadow_d;
  biquad_coeffs_t         active_q, active_d;
  logic                   from_settle_q, from_settle_d;
  logic                   reinit_q, reinit_d;
  logic                   mute_q, mute_d;
  logic                   pending_q, pending_d;
  logic [COUNT_WIDTH-1:0] update_count_q, update_count_d;

  logic quiet;
  logic apply;
  logic settle_dec;
  logic settle_zero;
  logic settle_done;

  assign quiet = !busy_i && !data_valid_i;
  // A commit in an otherwise quiet cycle wins over the apply so the newest set is used.
  assign apply = (state_q == ST_PENDING) && quiet && !commit_i;

  // The sample seen alongside reinit belongs to the old coefficients.
  assign settle_dec = (state_q == ST_SETTLE) && !reinit_q && filter_valid_i;

  sample_down_counter #(
    .WIDTH (CNT_W)
  ) u_settle_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (apply),
    .load_val_i (CNT_W'(SETTLE_SAMPLES)),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero),
    .done_o     (settle_done)
  );

  always_comb begin
    shadow_d = shadow_q;
    if (commit_i) begin
      shadow_d = '{a1: a1_i, a2: a2_i, b0: b0_i, b1: b1_i, b2: b2_i};
    end
  end

  always_comb begin
    state_d       = state_q;
    from_settle_d = from_settle_q;
    unique case (state_q)
      ST_IDLE: begin
        if (commit_i) begin
          state_d       = ST_PENDING;
          from_settle_d = 1'b0;
        end
      end
      ST_PENDING: begin
        if (apply) begin
          state_d       = (SETTLE_SAMPLES == 0) ? ST_IDLE : ST_SETTLE;
          from_settle_d = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (commit_i) begin
          state_d       = ST_PENDING;
          from_settle_d = 1'b1;
        end else if (settle_done || settle_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        from_settle_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    active_d       = active_q;
    reinit_d       = 1'b0;
    update_count_d = update_count_q;
    if (apply) begin
      active_d       = shadow_q;
      reinit_d       = 1'b1;
      update_count_d = update_count_q + 1'b1;
    end
    pending_d = (state_d == ST_PENDING);
    mute_d    = (state_d == ST_SETTLE) || ((state_d == ST_PENDING) && from_settle_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      shadow_q       <= COEFFS_ZERO;
      active_q       <= COEFFS_ZERO;
      from_settle_q  <= 1'b0;
      reinit_q       <= 1'b0;
      mute_q         <= 1'b0;
      pending_q      <= 1'b0;
      update_count_q <= '0;
    end else begin
      state_q        <= state_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      from_settle_q  <= from_settle_d;
      reinit_q       <= reinit_d;
      mute_q         <= mute_d;
      pending_q      <= pending_d;
      update_count_q <= update_count_d;
    end
  end

  assign a1_o           = active_q.a1;
  assign a2_o           = active_q.a2;
  assign b0_o           = active_q.b0;
  assign b1_o           = active_q.b1;
  assign b2_o           = active_q.b2;
  assign reinit_o       = reinit_q;
  assign mute_o         = mute_q;
  assign pending_o      = pending_q;
  assign update_count_o = update_count_q;

endmodule
